// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types and constants for the FIFO read controller and its local
// two-entry skid buffer.
//   rd_state_t  : read-controller state (IDLE, RUN, FLUSH)
//   DRAIN_CNT_W : width of the delivered-word counter
//   BUF_OCC_W   : width of the skid-buffer occupancy (0..2)
// -----------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_t;

  localparam int DRAIN_CNT_W = 16;
  localparam int BUF_OCC_W   = 2;

endpackage : fifo_pkg

// File: rtl/fifo_skid_buf.sv
// -----------------------------------------------------------------------------
// fifo_skid_buf
// Two-entry FIFO-ordered buffer sitting between the upstream FIFO read port
// and the downstream consumer. Writes land at the tail, reads take the head.
// A write and a read in the same cycle leave occupancy unchanged.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en       : write wr_data at the tail
//   wr_data     : data to write
//   rd_en       : remove the head entry
//   clr         : drop all entries (takes priority over wr_en/rd_en)
//   occ         : number of valid entries (0..2)
//   head_data   : oldest entry
// -----------------------------------------------------------------------------
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic                 clr,
  output logic [BUF_OCC_W-1:0] occ,
  output logic [WIDTH-1:0]     head_data
);

  logic [WIDTH-1:0]     mem_q [2];
  logic [WIDTH-1:0]     mem_d [2];
  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  logic [BUF_OCC_W-1:0] occ_q, occ_d;
  logic                 wr_ok, rd_ok;

  // Guards keep the buffer from over- or underflowing even if a caller
  // misbehaves; a write into a full buffer is only legal alongside a read.
  assign rd_ok = rd_en && (occ_q != '0);
  assign wr_ok = wr_en && ((occ_q != BUF_OCC_W'(2)) || rd_ok);

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clr) begin
      head_d = 1'b0;
      tail_d = 1'b0;
      occ_d  = '0;
    end else begin
      if (wr_ok) begin
        mem_d[tail_q] = wr_data;
        tail_d        = ~tail_q;
      end
      if (rd_ok) begin
        head_d = ~head_q;
      end
      occ_d = occ_q + {1'b0, wr_ok} - {1'b0, rd_ok};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = mem_q[head_q];

endmodule : fifo_skid_buf

// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
// Pops an upstream FIFO (1-cycle read latency) into a two-entry skid buffer
// and presents the buffer head to a valid/ready consumer at up to one word
// per cycle. A flush discards local contents and drains the upstream FIFO.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   out_is_empty  : upstream FIFO empty
//   fifo_rdata    : upstream read data, valid the cycle after in_read_ctrl
//   in_read_ctrl  : pop request to the upstream FIFO
//   flush         : single-cycle discard request
//   dout_valid    : dout_data valid
//   dout_data     : head of the local buffer
//   dout_ready    : consumer accepts dout_data
//   flush_done    : one-cycle pulse when a flush finishes
//   drain_count   : words delivered downstream, saturating
// -----------------------------------------------------------------------------
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ENTRIES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   out_is_empty,
  input  logic [WIDTH-1:0]       fifo_rdata,
  output logic                   in_read_ctrl,
  input  logic                   flush,
  output logic                   dout_valid,
  output logic [WIDTH-1:0]       dout_data,
  input  logic                   dout_ready,
  output logic                   flush_done,
  output logic [DRAIN_CNT_W-1:0] drain_count
);

  localparam int ENTRIES_LOG2 = $clog2(ENTRIES);

  // The controller never needs the upstream depth: it relies only on
  // out_is_empty and tracks at most one outstanding read.
  logic [31:0] unused_depth;
  assign unused_depth = 32'(ENTRIES_LOG2);

  function automatic logic [DRAIN_CNT_W-1:0] sat_inc(input logic [DRAIN_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  rd_state_t            state_q, state_d;
  logic                 inflight_q, inflight_d;
  logic                 flush_done_q, flush_done_d;
  logic [DRAIN_CNT_W-1:0] drain_cnt_q, drain_cnt_d;

  logic                 rd_req;
  logic                 buf_wr, buf_rd, buf_clr;
  logic [BUF_OCC_W-1:0] occ;
  logic [WIDTH-1:0]     head_data;
  logic                 xfer;
  logic [2:0]           level;

  assign dout_valid = (state_q == RUN) && (occ != '0);
  assign xfer       = dout_valid && dout_ready;

  // Entries the buffer will hold after this cycle if no new read is issued:
  // stored words plus the word already in flight, minus the one leaving now.
  // A new pop is safe only while that stays below the buffer depth.
  assign level = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, xfer};

  always_comb begin
    state_d      = state_q;
    rd_req       = 1'b0;
    buf_wr       = 1'b0;
    buf_rd       = 1'b0;
    buf_clr      = 1'b0;
    flush_done_d = 1'b0;
    drain_cnt_d  = drain_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!flush) state_d = RUN;
      end
      RUN: begin
        rd_req = !out_is_empty && (level < 3'd2);
        if (flush) begin
          // Flush wins: any handshake this cycle is neither removed nor counted.
          state_d = FLUSH;
          buf_clr = 1'b1;
        end else begin
          buf_wr = inflight_q;
          buf_rd = xfer;
          if (xfer) drain_cnt_d = sat_inc(drain_cnt_q);
        end
      end
      FLUSH: begin
        // Keep popping until upstream is empty; returning words are dropped.
        rd_req = !out_is_empty;
        if (out_is_empty && !inflight_q) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    inflight_d = rd_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      inflight_q   <= 1'b0;
      flush_done_q <= 1'b0;
      drain_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      flush_done_q <= flush_done_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  fifo_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (buf_wr),
    .wr_data   (fifo_rdata),
    .rd_en     (buf_rd),
    .clr       (buf_clr),
    .occ       (occ),
    .head_data (head_data)
  );

  assign in_read_ctrl = rd_req;
  assign dout_data    = head_data;
  assign flush_done   = flush_done_q;
  assign drain_count  = drain_cnt_q;

endmodule : fifo_read_ctrl

// File: tb/tb_fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_ctrl
// Bench for fifo_read_ctrl: a behavioural upstream FIFO with 1-cycle read
// latency, directed stimulus, and a scoreboard queue of expected words that a
// separate monitor thread pops on every counted downstream transfer.
// -----------------------------------------------------------------------------
module tb_fifo_read_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        out_is_empty;
  logic [7:0]  fifo_rdata;
  logic        in_read_ctrl;
  logic        flush;
  logic        dout_valid;
  logic [7:0]  dout_data;
  logic        dout_ready;
  logic        flush_done;
  logic [15:0] drain_count;

  always #5 clk = ~clk;

  fifo_read_ctrl #(
    .WIDTH   (8),
    .ENTRIES (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .out_is_empty (out_is_empty),
    .fifo_rdata   (fifo_rdata),
    .in_read_ctrl (in_read_ctrl),
    .flush        (flush),
    .dout_valid   (dout_valid),
    .dout_data    (dout_data),
    .dout_ready   (dout_ready),
    .flush_done   (flush_done),
    .drain_count  (drain_count)
  );

  // Upstream FIFO model: storage written by the stimulus, popped here.
  logic [7:0]  mem [0:131071];
  logic [16:0] wr_ptr = '0;
  logic [16:0] rd_ptr = '0;
  int          pop_cnt = 0;

  assign out_is_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (in_read_ctrl && (rd_ptr != wr_ptr)) begin
      fifo_rdata <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 17'd1;
      pop_cnt    <= pop_cnt + 1;
    end
  end

  // Scoreboard state
  logic [7:0]  exp_q [$];
  logic [15:0] exp_drain = '0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 17'd1;
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic [7:0] w;
    forever begin
      @(negedge clk);
      chk("rd_while_empty", 32'(in_read_ctrl && out_is_empty), 32'd0);
      chk("drain_count", 32'(drain_count), 32'(exp_drain));
      if (rst_n && dout_valid && dout_ready && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", dout_data);
        end else begin
          w = exp_q.pop_front();
          chk("dout_data", 32'(dout_data), 32'(w));
        end
        if (exp_drain != 16'hFFFF) exp_drain = exp_drain + 16'd1;
      end
    end
  endtask

  initial begin
    int base;
    int pulses;
    rst_n      = 1'b0;
    flush      = 1'b0;
    dout_ready = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    step();
    step();
    chk("rst_rd", 32'(in_read_ctrl), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    chk("rst_data", 32'(dout_data), 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_drain", 32'(drain_count), 32'd0);
    rst_n = 1'b1;
    step();
    step();

    // Three pre-loaded words, consumer always ready: back-to-back output
    dout_ready = 1'b1;
    push(8'hA1); push(8'hA2); push(8'hA3);
    step(); step();
    @(negedge clk);
    chk("lat_valid", 32'(dout_valid), 32'd1);
    chk("lat_a1", 32'(dout_data), 32'hA1);
    step();
    @(negedge clk);
    chk("seq_a2", 32'(dout_data), 32'hA2);
    step();
    @(negedge clk);
    chk("seq_a3", 32'(dout_data), 32'hA3);
    step();
    @(negedge clk);
    chk("t1_idle_valid", 32'(dout_valid), 32'd0);
    chk("t1_drain", 32'(drain_count), 32'd3);

    // Back-pressure: four words, consumer stalled five cycles
    step();
    dout_ready = 1'b0;
    base = pop_cnt;
    push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k >= 2) begin
        @(negedge clk);
        chk("stall_valid", 32'(dout_valid), 32'd1);
        chk("stall_hold", 32'(dout_data), 32'hB1);
      end
    end
    chk("stall_pops", 32'(pop_cnt - base), 32'd2);
    chk("stall_occ", 32'(dut.u_buf.occ_q), 32'd2);
    step();
    dout_ready = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("t2_all_out", 32'(exp_q.size()), 32'd0);
    chk("t2_pops", 32'(pop_cnt - base), 32'd4);
    chk("t2_drain", 32'(drain_count), 32'd7);

    // Flush with a full local buffer and two words left upstream
    dout_ready = 1'b0;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    for (int k = 0; k < 4; k++) step();
    @(negedge clk);
    chk("pre_flush_occ", 32'(dut.u_buf.occ_q), 32'd2);
    chk("pre_flush_fifo", 32'(wr_ptr - rd_ptr), 32'd2);
    step();
    flush = 1'b1;
    exp_q.delete();
    base   = pop_cnt;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      flush = (i == 2);
      @(negedge clk);
      if (i == 1) chk("flush_valid", 32'(dout_valid), 32'd0);
      if (flush_done) pulses++;
    end
    flush = 1'b0;
    chk("flush_pulses", 32'(pulses), 32'd1);
    chk("flush_pops", 32'(pop_cnt - base), 32'd2);
    chk("flush_drain", 32'(drain_count), 32'd7);

    // Flush coinciding with a transfer: that transfer is not counted
    step();
    dout_ready = 1'b1;
    push(8'hD1);
    step();
    step();
    flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("coinc_valid", 32'(dout_valid), 32'd1);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("coinc_after_valid", 32'(dout_valid), 32'd0);
    for (int k = 0; k < 6; k++) step();
    chk("coinc_drain", 32'(drain_count), 32'd7);
    chk("coinc_no_out", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset with a word in the buffer and one in flight
    dout_ready = 1'b0;
    push(8'hE1); push(8'hE2);
    step();
    step();
    chk("pre_rst_valid", 32'(dout_valid), 32'd1);
    chk("pre_rst_inflight", 32'(dut.inflight_q), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    exp_drain = '0;
    #1;
    chk("arst_rd", 32'(in_read_ctrl), 32'd0);
    chk("arst_valid", 32'(dout_valid), 32'd0);
    chk("arst_data", 32'(dout_data), 32'd0);
    chk("arst_flush_done", 32'(flush_done), 32'd0);
    chk("arst_drain", 32'(drain_count), 32'd0);
    step();
    rst_n = 1'b1;
    dout_ready = 1'b1;
    push(8'hF1);
    @(negedge clk);
    chk("post_rst_no_rd", 32'(in_read_ctrl), 32'd0);
    for (int k = 0; k < 6; k++) step();
    chk("post_rst_out", 32'(exp_q.size()), 32'd0);
    chk("post_rst_drain", 32'(drain_count), 32'd1);

    // Long stream to 16'hFFFE at full throughput, then saturation
    for (int i = 0; i < 65533; i++) push(8'(i));
    for (int k = 0; k < 65535; k++) step();
    chk("stream_rate", 32'(exp_q.size()), 32'd0);
    chk("stream_drain", 32'(drain_count), 32'hFFFE);
    push(8'h11); push(8'h22); push(8'h33);
    for (int k = 0; k < 5; k++) step();
    chk("sat_drain", 32'(drain_count), 32'hFFFF);
    for (int k = 0; k < 5; k++) step();
    chk("sat_hold", 32'(drain_count), 32'hFFFF);
    chk("sat_out", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_read_ctrl

// File: doc/fifo_read_ctrl.md
FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, data width; ENTRIES, default 4, depth of the upstream FIFO; ENTRIES_LOG2 = $clog2(ENTRIES), a localparam.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port out_is_empty, input, 1 bit: the upstream FIFO has no entries.
REQ-006 Port fifo_rdata, input, WIDTH bits: FIFO read data, valid exactly 1 cycle after in_read_ctrl is sampled high.
REQ-007 Port in_read_ctrl, output, 1 bit: pop request to the FIFO.
REQ-008 Port flush, input, 1 bit: single-cycle request to discard all FIFO and local contents.
REQ-009 Port dout_valid, output, 1 bit: dout_data is valid.
REQ-010 Port dout_data, output, WIDTH bits: head of the local buffer.
REQ-011 Port dout_ready, input, 1 bit: the consumer accepts data.
REQ-012 Port flush_done, output, 1 bit: one-cycle pulse when a flush completes.
REQ-013 Port drain_count, output, 16 bits: count of words delivered downstream, saturating at 16'hFFFF.

Function
REQ-014 The block SHALL hold a 2-entry local buffer (occ 0..2) and track one in-flight read (inflight bit).
REQ-015 The block SHALL assert in_read_ctrl only when !out_is_empty, so it never pops an empty FIFO.
REQ-016 In RUN, in_read_ctrl SHALL be asserted iff !out_is_empty and occ + inflight - (dout_valid && dout_ready) < 2.
REQ-017 inflight SHALL equal in_read_ctrl registered; when inflight=1, fifo_rdata SHALL be written to the buffer tail.
REQ-018 A transfer SHALL occur when dout_valid && dout_ready; the head is removed and the buffer order is FIFO.
REQ-019 Simultaneous write and transfer SHALL leave occ unchanged; the buffer SHALL never overflow (occ > 2) or underflow.
REQ-020 dout_valid SHALL equal (occ != 0) in RUN and 0 in IDLE and FLUSH; dout_data SHALL be stable while dout_valid && !dout_ready.
REQ-021 Throughput SHALL be 1 word/cycle with dout_ready=1 and the FIFO non-empty; first-word latency from out_is_empty falling is 2 cycles.
REQ-022 The state machine SHALL have three states: IDLE, RUN, FLUSH.
REQ-023 IDLE SHALL go to RUN on the next cycle unless flush is high.
REQ-024 RUN SHALL go to FLUSH when flush=1; flush wins over a simultaneous transfer, and that transfer does not count.
REQ-025 On entry to FLUSH, the buffer SHALL be cleared (occ=0).
REQ-026 In FLUSH, in_read_ctrl SHALL be asserted every cycle while !out_is_empty; returning data is discarded.
REQ-027 FLUSH SHALL go to IDLE when out_is_empty && !inflight, pulsing flush_done for that one cycle.
REQ-028 flush asserted during FLUSH SHALL be ignored.
REQ-029 drain_count SHALL increment by 1 per transfer and saturate; flush SHALL not clear it.

Reset
REQ-030 Asserting rst_n low SHALL immediately force: state=IDLE, occ=0, inflight=0, in_read_ctrl=0, dout_valid=0, dout_data=0, flush_done=0, drain_count=0.
REQ-031 Reset mid-read SHALL drop the in-flight word, which is never delivered.
REQ-032 After reset release, the first in_read_ctrl SHALL occur no earlier than the second rising edge.

Structure
REQ-033 Package fifo_pkg SHALL hold the state enum rd_state_t (IDLE, RUN, FLUSH) and the DRAIN_CNT_W=16 constant.
REQ-034 Sub-module fifo_skid_buf SHALL implement the 2-entry buffer (occ, head/tail pointers, wr/rd); the FSM and counter stay in the top level.

Verification
REQ-035 FIFO pre-loaded with 3 words (0xA1, 0xA2, 0xA3), dout_ready=1 -> outputs 0xA1, 0xA2, 0xA3 on consecutive cycles; drain_count=3; in_read_ctrl never high while out_is_empty=1.
REQ-036 dout_ready=0 for 5 cycles with the FIFO holding 4 words -> exactly 2 pops, occ=2, dout_data=first word held stable; on release, all 4 words are delivered in order.
REQ-037 flush pulse with occ=2 and the FIFO holding 2 words -> dout_valid=0 next cycle, 2 pops, flush_done pulses once, drain_count unchanged.
REQ-038 rst_n low for 1 cycle while inflight=1 -> all outputs are 0 asynchronously; the dropped word never appears on dout_data.
REQ-039 Force drain_count=16'hFFFE, then do 3 transfers -> drain_count=16'hFFFF and holds.
REQ-040 flush and a transfer in the same cycle -> the transfer does not count and drain_count is unchanged.
